// File: rtl/button_pkg.sv
// Shared constants and width helpers for the debounced button bank.
//   TICK_PERIOD_DEF  : default sample-tick period in clk cycles (40 ms at 100 MHz)
//   STABLE_TICKS_DEF : default consecutive disagreeing samples to accept a new level
//   LONG_TICKS_DEF   : default ticks of continuous press before a long-press event
//   cnt_w()          : bits needed to hold 0..max_val
package button_pkg;

    localparam int TICK_PERIOD_DEF  = 4_000_000;
    localparam int STABLE_TICKS_DEF = 3;
    localparam int LONG_TICKS_DEF   = 25;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_bank_if.sv
// Button bank pin/event bundle.
//   in_i         : raw asynchronous button pins
//   level_o      : debounced pressed state, 1 = pressed
//   press_o      : one-cycle pulse on debounced 0->1
//   release_o    : one-cycle pulse on debounced 1->0
//   long_press_o : one-cycle pulse when held long enough
//   tick_o       : one-cycle sample strobe
// master = the side driving the pins, slave = the button bank.
interface button_bank_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] in_i;
    logic [N_BTN-1:0] level_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] long_press_o;
    logic             tick_o;

    modport master (
        output in_i,
        input  level_o, press_o, release_o, long_press_o, tick_o
    );

    modport slave (
        input  in_i,
        output level_o, press_o, release_o, long_press_o, tick_o
    );
endinterface

// File: rtl/button_channel.sv
// One debounced button channel: 2-flop synchroniser, stability counter,
// hold counter and registered press/release/long-press pulses.
//   clk, rst     : system clock, async active-high reset
//   tick_i       : sample strobe; all evaluation happens only in tick cycles
//   in_i         : raw asynchronous pin
//   level_o      : debounced level (1 = pressed)
//   press_o      : pulse in the first cycle level_o reads 1
//   release_o    : pulse in the first cycle level_o reads 0
//   long_press_o : pulse when the hold counter reaches LONG_TICKS
module button_channel import button_pkg::*; #(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic in_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);
    localparam int STAB_W = cnt_w(STABLE_TICKS);
    localparam int HOLD_W = cnt_w(LONG_TICKS);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

    logic              sync1_q, sync2_q;
    logic              samp;
    logic              level_q, level_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    assign samp = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        level_d   = level_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick_i) begin
            if (samp == level_q) begin
                stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
                level_d   = samp;
                stab_d    = '0;
                press_d   = samp;
                release_d = ~samp;
            end else begin
                stab_d = stab_q + 1'b1;
            end
            // A release on this tick wins over a long-press that would
            // otherwise complete on the same tick.
            if (level_q) begin
                if (!level_d) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                    long_d = (hold_q == HOLD_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            level_q   <= 1'b0;
            stab_q    <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= in_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/button_bank.sv
// Bank of N_BTN independent debounced buttons sharing one sample-tick generator.
//   clk, rst : system clock, async active-high reset
//   bus      : button_bank_if slave (raw pins in, debounced level/events out, tick)
module button_bank import button_pkg::*; #(
    parameter int N_BTN        = 4,
    parameter int TICK_PERIOD  = TICK_PERIOD_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    button_bank_if.slave  bus
);
    localparam int TICK_W = cnt_w(TICK_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [N_BTN-1:0]  level_w, press_w, release_w, long_w;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .in_i         (bus.in_i[g]),
            .level_o      (level_w[g]),
            .press_o      (press_w[g]),
            .release_o    (release_w[g]),
            .long_press_o (long_w[g])
        );
    end

    assign bus.tick_o       = tick;
    assign bus.level_o      = level_w;
    assign bus.press_o      = press_w;
    assign bus.release_o    = release_w;
    assign bus.long_press_o = long_w;

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: an active-high and an active-low instance driven with
// complementary pins, both checked every cycle against a behavioural model.
module tb_button_bank;
    localparam int N = 4;
    localparam int P = 10;
    localparam int S = 3;
    localparam int L = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] in_v = '0;

    always #5 clk = ~clk;

    button_bank_if #(.N_BTN(N)) bus_h ();
    button_bank_if #(.N_BTN(N)) bus_l ();
    assign bus_h.in_i = in_v;
    assign bus_l.in_i = ~in_v;

    button_bank #(.N_BTN(N), .TICK_PERIOD(P), .STABLE_TICKS(S), .LONG_TICKS(L), .ACTIVE_LOW(1'b0))
        u_dut_h (.clk(clk), .rst(rst), .bus(bus_h));
    button_bank #(.N_BTN(N), .TICK_PERIOD(P), .STABLE_TICKS(S), .LONG_TICKS(L), .ACTIVE_LOW(1'b1))
        u_dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pressed value seen two edges late; a tick sample that
    // differs from the level extends a run of disagreements, S in a row flip it.
    int         edges;
    bit [N-1:0] d1, d2;
    bit [N-1:0] m_lvl, m_press, m_rel, m_long;
    bit         m_tick;
    int         run  [N];
    int         held [N];

    task model_step();
        bit tick_now;
        bit was;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (rst) begin
            edges  = 0;
            d1     = '0;
            d2     = '0;
            m_lvl  = '0;
            m_tick = 1'b0;
            for (int c = 0; c < N; c++) begin
                run[c]  = 0;
                held[c] = 0;
            end
        end else begin
            tick_now = ((edges % P) == P - 1);
            if (tick_now) begin
                for (int c = 0; c < N; c++) begin
                    was = m_lvl[c];
                    if (d2[c] == m_lvl[c]) begin
                        run[c] = 0;
                    end else begin
                        run[c]++;
                        if (run[c] == S) begin
                            m_lvl[c] = d2[c];
                            run[c]   = 0;
                            if (d2[c]) m_press[c] = 1'b1;
                            else       m_rel[c]   = 1'b1;
                        end
                    end
                    if (was) begin
                        if (!m_lvl[c]) begin
                            held[c] = 0;
                        end else if (held[c] < L) begin
                            held[c]++;
                            if (held[c] == L) m_long[c] = 1'b1;
                        end
                    end
                end
            end
            d2 = d1;
            d1 = in_v;
            edges++;
            m_tick = ((edges % P) == P - 1);
        end
    endtask

    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_long  [N];
    int cnt_tick;

    task clr_counts();
        cnt_tick = 0;
        for (int c = 0; c < N; c++) begin
            cnt_press[c] = 0;
            cnt_rel[c]   = 0;
            cnt_long[c]  = 0;
        end
    endtask

    task step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("level_h",   int'(bus_h.level_o),      int'(m_lvl));
            chk("press_h",   int'(bus_h.press_o),      int'(m_press));
            chk("release_h", int'(bus_h.release_o),    int'(m_rel));
            chk("long_h",    int'(bus_h.long_press_o), int'(m_long));
            chk("tick_h",    int'(bus_h.tick_o),       int'(m_tick));
            chk("level_l",   int'(bus_l.level_o),      int'(m_lvl));
            chk("press_l",   int'(bus_l.press_o),      int'(m_press));
            chk("release_l", int'(bus_l.release_o),    int'(m_rel));
            chk("long_l",    int'(bus_l.long_press_o), int'(m_long));
            chk("tick_l",    int'(bus_l.tick_o),       int'(m_tick));
            if (bus_h.tick_o) cnt_tick++;
            for (int c = 0; c < N; c++) begin
                if (bus_h.press_o[c])      cnt_press[c]++;
                if (bus_h.release_o[c])    cnt_rel[c]++;
                if (bus_h.long_press_o[c]) cnt_long[c]++;
            end
        end
    endtask

    task do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    int  k;
    int  k_tick;
    int  k_press;
    bit  found;
    int  dur [N];

    initial begin
        // Idle after reset: outputs quiet, tick every P cycles.
        step(2);
        rst = 1'b0;
        clr_counts();
        step(200);
        chk("idle_ticks", cnt_tick, 200 / P);
        chk("idle_press0", cnt_press[0], 0);

        // Single press on channel 0, then release.
        clr_counts();
        in_v[0] = 1'b1;
        step(60);
        chk("ch0_press_cnt", cnt_press[0], 1);
        chk("ch1_press_cnt", cnt_press[1], 0);
        in_v[0] = 1'b0;
        step(60);
        chk("ch0_release_cnt", cnt_rel[0], 1);

        // Bouncing channel 1 never qualifies.
        clr_counts();
        for (int i = 0; i < 7; i++) begin
            in_v[1] = ~in_v[1];
            step(15);
        end
        in_v[1] = 1'b0;
        step(60);
        chk("bounce_press", cnt_press[1], 0);
        chk("bounce_release", cnt_rel[1], 0);

        // Long hold on channel 2.
        clr_counts();
        in_v[2] = 1'b1;
        step(110);
        chk("long_press_once", cnt_long[2], 1);
        chk("hold_press_once", cnt_press[2], 1);
        in_v[2] = 1'b0;
        step(60);
        chk("long_release", cnt_rel[2], 1);
        chk("no_long_after", cnt_long[2], 1);

        // All channels pressed together pulse in the same cycle.
        in_v  = '1;
        found = 1'b0;
        k     = 0;
        while (!found && k < 60) begin
            step(1);
            k++;
            if (bus_h.press_o != '0) begin
                found = 1'b1;
                chk("press_all_same_cycle", int'(bus_h.press_o), 'hF);
            end
        end
        chk("press_all_seen", int'(found), 1);
        in_v = '0;
        step(60);

        // Reset mid-qualification aborts; after release press needs three fresh ticks.
        in_v[0] = 1'b1;
        k = 0;
        while (run[0] != 2 && k < 40) begin
            step(1);
            k++;
        end
        chk("qual_reached", run[0], 2);
        clr_counts();
        do_reset();
        k = 0;
        k_tick  = -1;
        k_press = -1;
        while (k_press < 0 && k < 60) begin
            step(1);
            k++;
            if (bus_h.tick_o && k_tick < 0) k_tick = k;
            if (bus_h.press_o[0]) k_press = k;
        end
        chk("first_tick_cycle", k_tick + 1, P);
        chk("press_after_reset", k_press, 3 * P);
        chk("press_cnt_reset", cnt_press[0], 1);
        in_v = '0;
        step(60);

        // Randomised pin activity with occasional resets.
        for (int c = 0; c < N; c++) dur[c] = $urandom_range(60, 1);
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    in_v[c] = ~in_v[c];
                    dur[c]  = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 1)
                                                          : $urandom_range(90, 15);
                end
            end
            if ($urandom_range(599, 0) == 0) do_reset();
            else step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
